intesn_item_feeder: RTL
=======================

# intesn_item_feeder

Sequencer that streams input items into the intESN reservoir core. It buffers items from an upstream valid/ready source in a small FIFO and drives the core's iItem/iEn/iStart interface: one iStart pulse per sequence, then one item per hold period with iEn high. It sits directly in front of intESN and replaces hand-driven stimulus of those pins.

## Interface

- idata_demention, 2, bit width of one input item (matches intESN idata_demention)
- fifo_depth, 8, FIFO entries; power of two, ≥2
- hold_cycles, 1, cycles each item is presented with oEn high; ≥1
- count_width, 8, width of oCount

- iClk  in  1  clock; all logic on rising edge
- iRst_n  in  1  synchronous, active-low reset
- iItem  in  idata_demention  upstream item
- iValid  in  1  upstream item valid
- iLast  in  1  upstream item is the last of its sequence
- oReady  out  1  FIFO can accept; transfer when iValid & oReady
- oItem  out  idata_demention  to intESN iItem
- oEn  out  1  to intESN iEn
- oStart  out  1  to intESN iStart; one-cycle pulse per sequence
- oBusy  out  1  high from START through DONE
- oDone  out  1  one-cycle pulse after the last item of a sequence
- oCount  out  count_width  items delivered in current sequence; saturates at all-ones

## Operation

- FIFO entry = {last, item}, width idata_demention+1. Push on iValid & oReady. Pop is internal, driven by the FSM.
- oReady = (fifo count != fifo_depth), decoded from the registered count. Push while full is impossible. Pushes while iRst_n=0 are discarded.
- Simultaneous push and pop: count unchanged; both take effect.
- FSM states: IDLE, START, STREAM, DONE.
  - IDLE: oEn=0, oStart=0. If FIFO non-empty → START.
  - START: oStart=1 for exactly one cycle, oEn=0, oCount cleared → STREAM.
  - STREAM, no item in hold, FIFO non-empty: pop. oItem←item, oEn=1, hold counter←hold_cycles−1, oCount+1.
  - STREAM, item in hold: keep oItem and oEn=1 while the hold counter counts down.
  - At the final hold cycle of an item whose last=1 → DONE. Otherwise pop the next entry in the same cycle if the FIFO is non-empty, so items are back-to-back with no gap.
  - STREAM, FIFO empty mid-sequence (underrun): oEn=0, oItem holds its last value, state stays STREAM, no oStart re-issued.
  - DONE: oDone=1 for one cycle, oEn=0. Next state: IDLE. The next sequence always gets a fresh START, even if the FIFO is already non-empty.
- oBusy=1 in START, STREAM, DONE.
- oCount increments once per item, not per hold cycle. It holds its value through DONE and IDLE until the next START.

## Timing

- All outputs registered.
- Reset values: oItem=0, oEn=0, oStart=0, oDone=0, oBusy=0, oCount=0, FIFO empty, state IDLE. oReady=1 from the first reset edge.
- Reset mid-sequence: on the next edge all state and the FIFO are cleared, and outputs take their reset values. No oDone is emitted.
- Latency, FIFO empty in IDLE, item pushed in cycle t:
  - FIFO non-empty at t+1
  - oStart=1 at t+2
  - first oEn=1 with oItem valid at t+3
- Items k and k+1 both present in FIFO: oEn stays high continuously. oItem changes every hold_cycles cycles.
- Last item's final oEn cycle at c: oDone=1 and oEn=0 at c+1. Earliest oStart of the next sequence is c+3.
- Item pushed during STREAM while the FIFO is empty (underrun): oEn=1 with that item two cycles after the push.

## Structure

- Shared package intesn_pkg:
  - FSM state enum (IDLE, START, STREAM, DONE)
  - FIFO entry typedef {last, item}
  - default-width localparams shared with intESN
- Sub-module intesn_feeder_fifo: synchronous FIFO with parameters width and depth. Ports: push, pop, wdata, rdata, count, full, empty.
- FSM, hold counter and output registers live in intesn_item_feeder.

## Test plan

- Reset: hold iRst_n=0 for 2 cycles with iValid=1 → all outputs 0 except oReady=1; FIFO empty after release.
- Single sequence, hold_cycles=1:
  - stimulus: push items 2'b10, 2'b01, 2'b11 (last) from t=0
  - required: oStart at t=2; oEn high t=3..5 with oItem 10, 01, 11; oDone at t=6; oCount=3
- hold_cycles=3, one item 2'b10 with last=1 → oEn high for exactly 3 cycles with oItem=10, then oDone; oCount=1.
- Underrun:
  - stimulus: push 2'b01, wait 5 cycles, push 2'b10 (last)
  - required: oEn low during the gap, oItem stays 01, no second oStart, oDone after item 10
- Full/backpressure, fifo_depth=8:
  - stimulus: 10 back-to-back items with iValid held
  - required: oReady drops once 8 are buffered; no item lost or duplicated; output order matches input order
- Reset mid-STREAM: assert iRst_n=0 during the 2nd of 4 items → next cycle oEn=0, oBusy=0, FIFO empty, no oDone.

Source files
------------

// File: rtl/intesn_pkg.sv
// -----------------------------------------------------------------------------
// intesn_pkg
// Definitions shared by the intESN item feeder and the intESN core: default
// widths, the feeder FSM state encoding and the FIFO entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package intesn_pkg;

  localparam int IDATA_DEMENTION = 2;
  localparam int FIFO_DEPTH      = 8;
  localparam int HOLD_CYCLES     = 1;
  localparam int COUNT_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feederState_e;

  // FIFO entry at the default item width; the feeder rebuilds the same layout
  // with its own parameterised width.
  typedef struct packed {
    logic                       last;
    logic [IDATA_DEMENTION-1:0] item;
  } feederEntry_t;

endpackage

// File: rtl/intesn_item_feeder_if.sv
// -----------------------------------------------------------------------------
// intesn_item_feeder_if
// Bundles the upstream valid/ready item stream and the intESN drive pins.
// Modports:
//   slave  - the feeder: consumes iItem/iValid/iLast, drives oReady and the
//            intESN-side outputs
//   master - the upstream source / observer: the opposite directions
// Signals:
//   iItem, iValid, iLast, oReady         upstream handshake
//   oItem, oEn, oStart                   to intESN iItem/iEn/iStart
//   oBusy, oDone, oCount                 sequence status
// -----------------------------------------------------------------------------
interface intesn_item_feeder_if #(
  parameter int idata_demention = 2,
  parameter int count_width     = 8
);

  logic [idata_demention-1:0] iItem;
  logic                       iValid;
  logic                       iLast;
  logic                       oReady;
  logic [idata_demention-1:0] oItem;
  logic                       oEn;
  logic                       oStart;
  logic                       oBusy;
  logic                       oDone;
  logic [count_width-1:0]     oCount;

  modport slave (
    input  iItem, iValid, iLast,
    output oReady, oItem, oEn, oStart, oBusy, oDone, oCount
  );

  modport master (
    output iItem, iValid, iLast,
    input  oReady, oItem, oEn, oStart, oBusy, oDone, oCount
  );

endinterface

// File: rtl/intesn_feeder_fifo.sv
// -----------------------------------------------------------------------------
// intesn_feeder_fifo
// Synchronous FIFO with registered occupancy count and show-ahead read data.
// Ports:
//   iClk   in   clock, rising edge
//   iRst_n in   synchronous active-low reset (empties the FIFO)
//   push   in   write wdata (ignored when full or in reset)
//   pop    in   drop the head entry (ignored when empty)
//   wdata  in   write data
//   rdata  out  head entry, valid while not empty
//   count  out  number of stored entries
//   full   out  count == depth
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module intesn_feeder_fifo #(
  parameter int width = 3,
  parameter int depth = 8
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst_n && doPush) mem_q[wrPtr_q] <= wdata;
  end

  assign rdata = mem_q[rdPtr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/intesn_item_feeder.sv
// -----------------------------------------------------------------------------
// intesn_item_feeder
// Buffers items from an upstream valid/ready source and sequences them into
// the intESN core: one oStart pulse per sequence, then each item held on oItem
// with oEn high for hold_cycles cycles, then a one-cycle oDone.
// Ports:
//   iClk   in   clock, rising edge
//   iRst_n in   synchronous active-low reset
//   bus    slave modport of intesn_item_feeder_if
//          (iItem/iValid/iLast/oReady upstream; oItem/oEn/oStart to intESN;
//           oBusy/oDone/oCount status)
// -----------------------------------------------------------------------------
module intesn_item_feeder
  import intesn_pkg::*;
#(
  parameter int idata_demention = IDATA_DEMENTION,
  parameter int fifo_depth      = FIFO_DEPTH,
  parameter int hold_cycles     = HOLD_CYCLES,
  parameter int count_width     = COUNT_WIDTH
) (
  input  logic               iClk,
  input  logic               iRst_n,
  intesn_item_feeder_if.slave bus
);

  localparam int EW = idata_demention + 1;
  localparam int CW = $clog2(fifo_depth) + 1;
  localparam int HW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;

  typedef struct packed {
    logic                       last;
    logic [idata_demention-1:0] item;
  } entry_t;

  entry_t         wEntry;
  entry_t         rEntry;
  logic [EW-1:0]  rData;
  logic [CW-1:0]  fifoCount;
  logic           fifoFull;
  logic           fifoEmpty;
  logic           fifoPush;
  logic           fifoPop;
  logic           needItem;

  feederState_e               state_q,   state_d;
  logic [HW-1:0]              holdCnt_q, holdCnt_d;
  logic                       curLast_q, curLast_d;
  logic [idata_demention-1:0] oItem_q,   oItem_d;
  logic                       oEn_q,     oEn_d;
  logic                       oStart_q,  oStart_d;
  logic                       oDone_q,   oDone_d;
  logic                       oBusy_q,   oBusy_d;
  logic [count_width-1:0]     oCount_q,  oCount_d;

  assign wEntry   = {bus.iLast, bus.iItem};
  assign fifoPush = bus.iValid & ~fifoFull;
  assign rEntry   = rData;

  intesn_feeder_fifo #(
    .width (EW),
    .depth (fifo_depth)
  ) uFifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .push   (fifoPush),
    .pop    (fifoPop),
    .wdata  (wEntry),
    .rdata  (rData),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Outputs are registered, so every decision below describes what the core
  // sees in the next cycle. START already requests the first item so that it
  // appears on oItem the cycle after the oStart pulse.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    curLast_d = curLast_q;
    oItem_d   = oItem_q;
    oEn_d     = 1'b0;
    oStart_d  = 1'b0;
    oDone_d   = 1'b0;
    oCount_d  = oCount_q;
    fifoPop   = 1'b0;
    needItem  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          state_d  = START;
          oStart_d = 1'b1;
          oCount_d = '0;
        end
      end
      START: begin
        state_d  = STREAM;
        needItem = 1'b1;
      end
      STREAM: begin
        if (oEn_q && (holdCnt_q != '0)) begin
          oEn_d     = 1'b1;
          holdCnt_d = holdCnt_q - HW'(1);
        end else if (oEn_q && curLast_q) begin
          state_d = DONE;
          oDone_d = 1'b1;
        end else begin
          // Either the final hold cycle of a non-last item or an underrun:
          // fetch the next entry if one is waiting.
          needItem = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // On underrun oItem keeps its last value and oEn stays low.
    if (needItem && !fifoEmpty) begin
      fifoPop   = 1'b1;
      oItem_d   = rEntry.item;
      curLast_d = rEntry.last;
      oEn_d     = 1'b1;
      holdCnt_d = HW'(hold_cycles - 1);
      if (oCount_q != '1) oCount_d = oCount_q + count_width'(1);
    end

    oBusy_d = (state_d != IDLE);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      curLast_q <= 1'b0;
      oItem_q   <= '0;
      oEn_q     <= 1'b0;
      oStart_q  <= 1'b0;
      oDone_q   <= 1'b0;
      oBusy_q   <= 1'b0;
      oCount_q  <= '0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      curLast_q <= curLast_d;
      oItem_q   <= oItem_d;
      oEn_q     <= oEn_d;
      oStart_q  <= oStart_d;
      oDone_q   <= oDone_d;
      oBusy_q   <= oBusy_d;
      oCount_q  <= oCount_d;
    end
  end

  assign bus.oReady = (fifoCount != CW'(fifo_depth));
  assign bus.oItem  = oItem_q;
  assign bus.oEn    = oEn_q;
  assign bus.oStart = oStart_q;
  assign bus.oDone  = oDone_q;
  assign bus.oBusy  = oBusy_q;
  assign bus.oCount = oCount_q;

endmodule
